// File: rtl/ysyx_22051468_pc_redirect_ctrl_if.sv
// Fetch/redirect bundle between the execute stage, the PC controller and
// instruction memory. The master side is the PC controller itself.
interface ysyx_22051468_pc_redirect_ctrl_if #(
  parameter int WIDTH = 64
);
  // Execute-stage control towards the PC controller
  logic             branch_jump_en_i;
  logic [WIDTH-1:0] branch_jump_addr_i;
  logic             hold_pipeline_en_i;
  logic             halt_i;
  // Instruction memory handshake
  logic             fetch_ready_i;
  logic             fetch_valid_o;
  logic [WIDTH-1:0] pc_o;
  // Pipeline control and status
  logic             flush_o;
  logic             misalign_o;
  logic [1:0]       state_o;

  modport master (
    input  branch_jump_en_i,
    input  branch_jump_addr_i,
    input  hold_pipeline_en_i,
    input  halt_i,
    input  fetch_ready_i,
    output fetch_valid_o,
    output pc_o,
    output flush_o,
    output misalign_o,
    output state_o
  );

  modport slave (
    output branch_jump_en_i,
    output branch_jump_addr_i,
    output hold_pipeline_en_i,
    output halt_i,
    output fetch_ready_i,
    input  fetch_valid_o,
    input  pc_o,
    input  flush_o,
    input  misalign_o,
    input  state_o
  );
endinterface

// File: rtl/ysyx_22051468_pc_redirect_ctrl.sv
// Fetch PC owner: issues instruction fetches over a valid/ready handshake,
// redirects on taken branches/jumps with a fixed-length flush window, and
// stops fetching for good on ebreak or on a misaligned redirect target.
module ysyx_22051468_pc_redirect_ctrl #(
  parameter int              WIDTH        = 64,
  parameter logic [WIDTH-1:0] RESET_PC    = 64'h0000_0000_8000_0000,
  parameter int              FLUSH_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  ysyx_22051468_pc_redirect_ctrl_if.master bus
);

  localparam int CNT_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2,
    ST_ERR   = 2'd3
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] pc_reg;
  logic             flush_reg;
  logic             misalign_reg;
  logic             boot_reg;
  logic [CNT_W-1:0] flush_cnt_reg;
  logic             fetch_valid;
  logic             target_misaligned;

  // A request is only offered once out of reset, while running and not stalled.
  // Dropping it on a stall is safe: the PC cannot move while the request is low.
  always_comb begin
    fetch_valid = boot_reg & (state_reg == ST_RUN) & ~bus.hold_pipeline_en_i;
  end

  assign target_misaligned = (bus.branch_jump_addr_i[1:0] != 2'b00);

  // PC, control FSM and registered pipeline-control outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_RUN;
      pc_reg        <= RESET_PC;
      flush_reg     <= 1'b0;
      misalign_reg  <= 1'b0;
      boot_reg      <= 1'b0;
      flush_cnt_reg <= '0;
    end else begin
      boot_reg <= 1'b1;
      case (state_reg)
        ST_RUN: begin
          if (bus.halt_i) begin
            state_reg <= ST_HALT;
          end else if (bus.branch_jump_en_i && target_misaligned) begin
            state_reg    <= ST_ERR;
            misalign_reg <= 1'b1;
          end else if (bus.branch_jump_en_i) begin
            // Any fetch accepted this cycle belongs to the wrong path; the
            // redirect target simply overwrites the incremented PC.
            pc_reg        <= bus.branch_jump_addr_i;
            flush_reg     <= 1'b1;
            flush_cnt_reg <= CNT_W'(FLUSH_CYCLES - 1);
            state_reg     <= ST_FLUSH;
          end else if (bus.hold_pipeline_en_i) begin
            pc_reg <= pc_reg;
          end else if (fetch_valid && bus.fetch_ready_i) begin
            pc_reg <= pc_reg + WIDTH'(4);
          end
        end
        ST_FLUSH: begin
          // Execute only carries bubbles here, so redirect/stall are ignored.
          if (bus.halt_i) begin
            state_reg <= ST_HALT;
            flush_reg <= 1'b0;
          end else if (flush_cnt_reg == '0) begin
            state_reg <= ST_RUN;
            flush_reg <= 1'b0;
          end else begin
            flush_cnt_reg <= flush_cnt_reg - CNT_W'(1);
          end
        end
        default: begin
          // HALT and ERR are terminal until reset; everything stays frozen.
          flush_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc_o          = pc_reg;
  assign bus.fetch_valid_o = fetch_valid;
  assign bus.flush_o       = flush_reg;
  assign bus.misalign_o    = misalign_reg;
  assign bus.state_o       = state_reg;

endmodule

// File: tb/tb_ysyx_22051468_pc_redirect_ctrl.sv
// Directed bench for the fetch PC controller. Instance A uses the default
// reset PC; instance B uses a reset PC at the top of the address space to
// exercise wrap-around and an asynchronous reset during a flush window.
module tb_ysyx_22051468_pc_redirect_ctrl;

  localparam int W = 64;
  localparam logic [W-1:0] PC_A = 64'h0000_0000_8000_0000;
  localparam logic [W-1:0] PC_B = 64'hFFFF_FFFF_FFFF_FFFC;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   n_checks = 0;
  int   n_fails  = 0;

  ysyx_22051468_pc_redirect_ctrl_if #(.WIDTH(W)) bus_a ();
  ysyx_22051468_pc_redirect_ctrl_if #(.WIDTH(W)) bus_b ();

  ysyx_22051468_pc_redirect_ctrl #(.WIDTH(W), .RESET_PC(PC_A), .FLUSH_CYCLES(2)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a.master)
  );

  ysyx_22051468_pc_redirect_ctrl #(.WIDTH(W), .RESET_PC(PC_B), .FLUSH_CYCLES(2)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b.master)
  );

  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are then changed and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.branch_jump_en_i   = 1'b0;
    bus_a.branch_jump_addr_i = '0;
    bus_a.hold_pipeline_en_i = 1'b0;
    bus_a.halt_i             = 1'b0;
    bus_a.fetch_ready_i      = 1'b1;
    bus_b.branch_jump_en_i   = 1'b0;
    bus_b.branch_jump_addr_i = '0;
    bus_b.hold_pipeline_en_i = 1'b0;
    bus_b.halt_i             = 1'b0;
    bus_b.fetch_ready_i      = 1'b0;

    // 1 Boot
    repeat (3) tick();
    chk("reset_pc", bus_a.pc_o, PC_A);
    chk("reset_flush", W'(bus_a.flush_o), 64'd0);
    chk("reset_state", W'(bus_a.state_o), 64'd0);
    rst_a = 1'b0;
    chk("boot_valid0", W'(bus_a.fetch_valid_o), 64'd0);
    chk("boot_pc0", bus_a.pc_o, PC_A);
    tick();
    chk("boot_valid1", W'(bus_a.fetch_valid_o), 64'd1);
    chk("boot_pc1", bus_a.pc_o, 64'h8000_0000);
    tick();
    chk("boot_pc2", bus_a.pc_o, 64'h8000_0004);
    tick();
    chk("boot_pc3", bus_a.pc_o, 64'h8000_0008);

    // 2 Backpressure
    bus_a.fetch_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_valid", W'(bus_a.fetch_valid_o), 64'd1);
      chk("bp_pc", bus_a.pc_o, 64'h8000_0008);
    end
    bus_a.fetch_ready_i = 1'b1;
    tick();
    chk("bp_release_pc", bus_a.pc_o, 64'h8000_000C);

    // 3 Redirect (fetch handshake in the same cycle is discarded)
    bus_a.branch_jump_en_i   = 1'b1;
    bus_a.branch_jump_addr_i = 64'h8000_1000;
    tick();
    bus_a.branch_jump_en_i = 1'b0;
    chk("redir_pc", bus_a.pc_o, 64'h8000_1000);
    chk("redir_flush1", W'(bus_a.flush_o), 64'd1);
    chk("redir_valid1", W'(bus_a.fetch_valid_o), 64'd0);
    chk("redir_state", W'(bus_a.state_o), 64'd1);
    tick();
    chk("redir_flush2", W'(bus_a.flush_o), 64'd1);
    chk("redir_valid2", W'(bus_a.fetch_valid_o), 64'd0);
    tick();
    chk("redir_flush_end", W'(bus_a.flush_o), 64'd0);
    chk("redir_valid_back", W'(bus_a.fetch_valid_o), 64'd1);
    chk("redir_state_run", W'(bus_a.state_o), 64'd0);
    chk("redir_pc_hold", bus_a.pc_o, 64'h8000_1000);
    tick();
    chk("redir_first_fetch", bus_a.pc_o, 64'h8000_1004);

    // 4 Misaligned target
    bus_a.branch_jump_en_i   = 1'b1;
    bus_a.branch_jump_addr_i = 64'h8000_1002;
    tick();
    bus_a.branch_jump_en_i = 1'b0;
    chk("mis_state", W'(bus_a.state_o), 64'd3);
    chk("mis_flag", W'(bus_a.misalign_o), 64'd1);
    chk("mis_pc", bus_a.pc_o, 64'h8000_1004);
    chk("mis_flush", W'(bus_a.flush_o), 64'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("mis_valid", W'(bus_a.fetch_valid_o), 64'd0);
      chk("mis_sticky", W'(bus_a.state_o), 64'd3);
    end
    #2;
    rst_a = 1'b1;
    #1;
    chk("mis_rst_flag", W'(bus_a.misalign_o), 64'd0);
    chk("mis_rst_state", W'(bus_a.state_o), 64'd0);
    chk("mis_rst_pc", bus_a.pc_o, PC_A);
    tick();
    rst_a = 1'b0;
    tick();
    chk("reboot_valid", W'(bus_a.fetch_valid_o), 64'd1);

    // Stall: no request and PC held
    bus_a.hold_pipeline_en_i = 1'b1;
    #1;
    chk("hold_valid", W'(bus_a.fetch_valid_o), 64'd0);
    tick();
    chk("hold_pc", bus_a.pc_o, PC_A);
    bus_a.hold_pipeline_en_i = 1'b0;

    // 5 Halt beats a simultaneous redirect
    bus_a.halt_i             = 1'b1;
    bus_a.branch_jump_en_i   = 1'b1;
    bus_a.branch_jump_addr_i = 64'h8000_2000;
    tick();
    bus_a.halt_i           = 1'b0;
    bus_a.branch_jump_en_i = 1'b0;
    chk("halt_state", W'(bus_a.state_o), 64'd2);
    chk("halt_pc", bus_a.pc_o, PC_A);
    chk("halt_flush", W'(bus_a.flush_o), 64'd0);
    chk("halt_valid", W'(bus_a.fetch_valid_o), 64'd0);
    repeat (20) tick();
    chk("halt_sticky", W'(bus_a.state_o), 64'd2);
    chk("halt_pc_frozen", bus_a.pc_o, PC_A);

    // 6 Wrap and asynchronous reset during FLUSH (instance B)
    rst_b = 1'b0;
    bus_b.fetch_ready_i = 1'b1;
    tick();
    chk("wrap_valid", W'(bus_b.fetch_valid_o), 64'd1);
    chk("wrap_pc_top", bus_b.pc_o, PC_B);
    tick();
    chk("wrap_pc_zero", bus_b.pc_o, 64'd0);
    bus_b.branch_jump_en_i   = 1'b1;
    bus_b.branch_jump_addr_i = 64'h0000_0000_0000_0100;
    tick();
    bus_b.branch_jump_en_i = 1'b0;
    chk("wrap_redir_pc", bus_b.pc_o, 64'h100);
    chk("wrap_redir_flush", W'(bus_b.flush_o), 64'd1);
    #2;
    rst_b = 1'b1;
    #1;
    chk("async_rst_pc", bus_b.pc_o, PC_B);
    chk("async_rst_flush", W'(bus_b.flush_o), 64'd0);
    chk("async_rst_state", W'(bus_b.state_o), 64'd0);
    chk("async_rst_valid", W'(bus_b.fetch_valid_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
